// File: rtl/uart_debug_cmd.sv
// uart_debug_cmd: UART debug command parser.
// Turns received UART bytes into single debug access requests (word write 'W',
// byte write 'B', word read 'R'). Each request is issued as a one-cycle
// uart_debug_req pulse. The parser then waits for store_finish/load_finish and
// answers through the UART transmitter: an ack byte for writes, or the 4 read
// data bytes (LSB first) for reads.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data/rx_valid      received byte strobe (no backpressure)
//   tx_data/tx_valid/tx_ready  transmit byte handshake
//   uart_debug_*          access request towards the AXI access engine
//   store_finish/load_finish/load_rdata  access completion
//   busy                  parser not idle
//   err_cnt               saturating count of bad-opcode and timeout aborts
module uart_debug_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  CMD_WORD_WR    = 8'h57,
  parameter logic [7:0]  CMD_BYTE_WR    = 8'h42,
  parameter logic [7:0]  CMD_WORD_RD    = 8'h52
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        uart_debug_req,
  output logic        uart_debug_we,
  output logic [31:0] uart_debug_addr,
  output logic [31:0] uart_debug_wdata,
  output logic        uart_debug_stb,
  input  logic        store_finish,
  input  logic        load_finish,
  input  logic [31:0] load_rdata,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ACK_BYTE = 8'h4B;
  localparam logic [7:0] ERR_BYTE = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_RESP, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt;
  logic          op_rd, op_byte;
  logic [31:0]   addr_sh, data_sh;
  logic [31:0]   addr_nx, data_nx;
  logic [TW-1:0] to_cnt;
  logic [31:0]   resp_sh;
  logic [1:0]    resp_left;
  logic          op_valid, timeout_hit, finish_hit, tx_fire, err_inc;

  assign op_valid    = (rx_data == CMD_WORD_WR) || (rx_data == CMD_BYTE_WR) ||
                       (rx_data == CMD_WORD_RD);
  assign timeout_hit = ((state_q == S_ADDR) || (state_q == S_DATA)) &&
                       !rx_valid && (to_cnt == TO_LAST);
  assign finish_hit  = op_rd ? load_finish : store_finish;
  assign tx_fire     = tx_valid && tx_ready;
  assign err_inc     = ((state_q == S_IDLE) && rx_valid && !op_valid) || timeout_hit;

  // Shift-in values including the byte arriving this cycle; used both to
  // update the shift registers and to load the request fields directly on
  // the final packet byte so the request appears one cycle later.
  assign addr_nx = {rx_data, addr_sh[31:8]};
  assign data_nx = op_byte ? {24'h0, rx_data} : {rx_data, data_sh[31:8]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_valid) state_d = op_valid ? S_ADDR : S_ERR;
      S_ADDR: begin
        if (rx_valid) begin
          if (byte_cnt == 2'd3) state_d = op_rd ? S_ISSUE : S_DATA;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (op_byte || (byte_cnt == 2'd3)) state_d = S_ISSUE;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (finish_hit) state_d = S_RESP;
      S_RESP:  if (tx_fire && (resp_left == 2'd0)) state_d = S_IDLE;
      S_ERR:   if (tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy           = (state_q != S_IDLE);
    uart_debug_req = (state_q == S_ISSUE);
    tx_valid       = 1'b0;
    tx_data        = '0;
    case (state_q)
      S_RESP: begin tx_valid = 1'b1; tx_data = resp_sh[7:0]; end
      S_ERR:  begin tx_valid = 1'b1; tx_data = ERR_BYTE;     end
      default: ;
    endcase
  end

  // Packet assembly, request fields and response shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt         <= '0;
      op_rd            <= 1'b0;
      op_byte          <= 1'b0;
      addr_sh          <= '0;
      data_sh          <= '0;
      to_cnt           <= '0;
      resp_sh          <= '0;
      resp_left        <= '0;
      uart_debug_we    <= 1'b0;
      uart_debug_stb   <= 1'b0;
      uart_debug_addr  <= '0;
      uart_debug_wdata <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          byte_cnt <= '0;
          to_cnt   <= '0;
          if (rx_valid) begin
            op_rd   <= (rx_data == CMD_WORD_RD);
            op_byte <= (rx_data == CMD_BYTE_WR);
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            to_cnt   <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state_q == S_ADDR) addr_sh <= addr_nx;
            else                   data_sh <= data_nx;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (finish_hit) begin
            resp_sh   <= op_rd ? load_rdata : {24'h0, ACK_BYTE};
            resp_left <= op_rd ? 2'd3 : 2'd0;
          end
        end
        S_RESP: begin
          if (tx_fire) begin
            resp_sh   <= {8'h0, resp_sh[31:8]};
            resp_left <= resp_left - 2'd1;
          end
        end
        default: ;
      endcase

      if ((state_d == S_ISSUE) && (state_q != S_ISSUE)) begin
        uart_debug_we    <= !op_rd;
        uart_debug_stb   <= op_byte;
        uart_debug_addr  <= (state_q == S_ADDR) ? addr_nx : addr_sh;
        uart_debug_wdata <= op_rd ? '0 : data_nx;
      end
    end
  end

  // Saturating abort counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_cnt <= '0;
    else if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
  end

endmodule
